// File: rtl/fan_pwm_driver.sv
// Fan PWM actuator: scales and clamps the PID output into a duty target, then drives
// a glitch-free PWM with a soft-start ramp. Optional stall floor: `FAN_PWM_MIN_SPIN_EN.
//
// state     | meaning
// IDLE      | drive off, counter parked at 0
// SOFTSTART | duty ramps toward the target by RAMP_STEP per period
// RUN       | duty tracks the target at every period boundary
module fan_pwm_driver #(
  parameter int PERIOD    = 1000,
  parameter int DUTY_W    = 10,
  parameter int SHIFT     = 4,
  parameter int RAMP_STEP = 10,
  parameter int MIN_DUTY  = 20
) (
  input  logic                CLK,
  input  logic                nRST2,
  input  logic                EN,
  input  logic signed [31:0]  PID_OUTPUT,
  input  logic                PID_VALID,
  output logic                PWM_OUT,
  output logic [DUTY_W-1:0]   DUTY,
  output logic                PERIOD_END,
  output logic                SAT_HI,
  output logic                SAT_LO,
  output logic [1:0]          STATE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOFT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [DUTY_W-1:0]   PERIOD_D  = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0]   PERIOD_M1 = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W:0]     RAMP_D    = (DUTY_W + 1)'(RAMP_STEP);
  localparam logic signed [31:0]  PERIOD_S  = 32'(PERIOD);

  if (PERIOD > (1 << DUTY_W) - 1 || MIN_DUTY > PERIOD) begin : g_param_check
    $error("fan_pwm_driver: PERIOD must fit DUTY_W and MIN_DUTY must not exceed PERIOD");
  end

  state_e              state_q, state_d;
  logic [DUTY_W-1:0]   cnt_q, cnt_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic [DUTY_W-1:0]   target_q, target_d;
  logic                sat_hi_q, sat_hi_d;
  logic                sat_lo_q, sat_lo_d;
  logic signed [31:0]  v;
  logic [DUTY_W:0]     ramp_sum;
  logic                period_end;

  assign v          = PID_OUTPUT >>> SHIFT;
  assign period_end = (state_q != ST_IDLE) && (cnt_q == PERIOD_M1);

  // Clamp at full signed width; truncation happens only once the value is in range.
  always_comb begin
    target_d = target_q;
    sat_hi_d = sat_hi_q;
    sat_lo_d = sat_lo_q;
    if (PID_VALID) begin
      if (v < 32'sd0) begin
        target_d = '0;
        sat_lo_d = 1'b1;
        sat_hi_d = 1'b0;
      end else if (v > PERIOD_S) begin
        target_d = PERIOD_D;
        sat_hi_d = 1'b1;
        sat_lo_d = 1'b0;
      end else begin
        target_d = v[DUTY_W-1:0];
        sat_hi_d = 1'b0;
        sat_lo_d = 1'b0;
`ifdef FAN_PWM_MIN_SPIN_EN
        if ((v != 32'sd0) && (v < 32'(MIN_DUTY))) begin
          target_d = DUTY_W'(MIN_DUTY);
        end
`endif
      end
    end
  end

  // Duty only moves on the wrap edge, so a period never sees two compare values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    duty_d   = duty_q;
    ramp_sum = {1'b0, duty_q} + RAMP_D;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        duty_d = '0;
        if (EN) begin
          state_d = ST_SOFT;
        end
      end
      ST_SOFT: begin
        cnt_d = period_end ? '0 : cnt_q + 1'b1;
        if (period_end) begin
          if (target_q <= duty_q) begin
            duty_d  = target_q;
            state_d = ST_RUN;
          end else if (ramp_sum >= {1'b0, target_q}) begin
            duty_d  = target_q;
            state_d = ST_RUN;
          end else begin
            duty_d = ramp_sum[DUTY_W-1:0];
          end
        end
      end
      ST_RUN: begin
        cnt_d = period_end ? '0 : cnt_q + 1'b1;
        if (period_end) begin
          duty_d = target_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        duty_d  = '0;
      end
    endcase
    if (!EN) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      duty_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST2) begin
    if (!nRST2) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      duty_q   <= '0;
      target_q <= '0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end

  assign PWM_OUT    = (state_q != ST_IDLE) && (cnt_q < duty_q);
  assign DUTY       = duty_q;
  assign PERIOD_END = period_end;
  assign SAT_HI     = sat_hi_q;
  assign SAT_LO     = sat_lo_q;
  assign STATE      = state_q;

endmodule
